mips_fetch_queue: RTL

Parametrised instruction-fetch front end for the pipelined MIPS core, between instruction memory and the decode stage. It generates sequential fetch addresses and issues them over a request/grant memory port that tolerates variable latency. Returned instructions are buffered, each tagged with its PC, in a DEPTH-entry queue. On a branch or jump redirect it flushes the queue and silently drops stale in-flight responses, so decode can stall without losing instructions.

---
 rtl/mips_pkg.sv | 15 +
 rtl/mips_fetchq_fifo.sv | 54 +++++
 rtl/mips_fetch_queue.sv | 137 +++++++++++++
 3 files changed

// File: rtl/mips_pkg.sv
// Shared types for the MIPS instruction-fetch path: instruction word and
// the {pc, instr} entry carried through the fetch queue.
package mips_pkg;

    localparam int MIPS_XLEN   = 32;
    localparam int INSTR_BYTES = 4;

    typedef logic [31:0] instr_t;

    typedef struct packed {
        logic [MIPS_XLEN-1:0] pc;
        instr_t               instr;
    } fetch_entry_t;

endpackage

// File: rtl/mips_fetchq_fifo.sv
// Circular FIFO of fetch entries with push/pop/clear and an occupancy count.
// Head entry is read combinationally so decode sees it the cycle after the push.
module mips_fetchq_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         clear,
    input  logic                         push,
    input  logic                         pop,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   wr_ptr_reg;
    logic [PW-1:0]   rd_ptr_reg;
    logic [CW-1:0]   count_reg;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (clear) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PW'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PW'(1);
            case ({push, pop})
                2'b10:   count_reg <= count_reg + CW'(1);
                2'b01:   count_reg <= count_reg - CW'(1);
                default: count_reg <= count_reg;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push && !clear) mem[wr_ptr_reg] <= din;
    end

    assign dout  = mem[rd_ptr_reg];
    assign count = count_reg;

endmodule

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: credit-limited request issue, PC tagging,
// redirect flush with stale-response dropping. Option: MIPS_FETCHQ_BYPASS_EN.
module mips_fetch_queue
    import mips_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [31:0]     imem_rdata,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            instr_valid,
    output logic [31:0]     instr,
    output logic [XLEN-1:0] instr_pc,
    input  logic            instr_ready
);

    localparam int CW = $clog2(DEPTH+1);
    localparam int SW = CW + 2;

    logic [XLEN-1:0] fetch_pc_reg, fetch_pc_next;
    logic [XLEN-1:0] resp_pc_reg, resp_pc_next;
    logic [CW-1:0]   outstanding_reg, outstanding_next;
    logic [CW-1:0]   drop_reg, drop_next;
    logic [CW-1:0]   count;
    logic [SW-1:0]   credit_used;

    fetch_entry_t    push_entry;
    fetch_entry_t    head_entry;
    logic            gnt_fire;
    logic            resp_drop;
    logic            resp_take;
    logic            fifo_push;
    logic            fifo_pop;
    logic            head_valid;

    assign credit_used = SW'(count) + SW'(outstanding_reg) + SW'(drop_reg);
    assign imem_req    = reset && !redirect && (credit_used < SW'(DEPTH));
    assign imem_addr   = fetch_pc_reg;
    assign gnt_fire    = imem_req && imem_gnt;

    // A response with nothing outstanding and nothing to drop is ignored.
    assign resp_drop   = imem_rvalid && (drop_reg != '0);
    assign resp_take   = imem_rvalid && (drop_reg == '0) && (outstanding_reg != '0);

    assign head_valid  = (count != '0);
    assign fifo_pop    = head_valid && instr_ready && !redirect;

`ifdef MIPS_FETCHQ_BYPASS_EN
    logic bypass_hit;
    assign bypass_hit = !head_valid && !redirect && resp_take;
    assign fifo_push  = resp_take && !redirect && !(bypass_hit && instr_ready);
`else
    assign fifo_push  = resp_take && !redirect;
`endif

    assign push_entry.pc    = MIPS_XLEN'(resp_pc_reg);
    assign push_entry.instr = imem_rdata;

    mips_fetchq_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (redirect),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (push_entry),
        .dout  (head_entry),
        .count (count)
    );

    always_comb begin
        instr_valid = 1'b0;
        instr       = '0;
        instr_pc    = '0;
        if (head_valid) begin
            instr_valid = !redirect;
            instr       = head_entry.instr;
            instr_pc    = XLEN'(head_entry.pc);
        end
`ifdef MIPS_FETCHQ_BYPASS_EN
        else if (bypass_hit) begin
            instr_valid = 1'b1;
            instr       = imem_rdata;
            instr_pc    = resp_pc_reg;
        end
`endif
    end

    always_comb begin
        fetch_pc_next    = fetch_pc_reg;
        resp_pc_next     = resp_pc_reg;
        outstanding_next = outstanding_reg;
        drop_next        = drop_reg;
        if (redirect) begin
            // Everything in flight becomes stale, minus a response landing now.
            fetch_pc_next    = redirect_pc;
            resp_pc_next     = redirect_pc;
            outstanding_next = '0;
            drop_next        = drop_reg + outstanding_reg
                             - ((resp_drop || resp_take) ? CW'(1) : CW'(0));
        end else begin
            if (gnt_fire)  fetch_pc_next = fetch_pc_reg + XLEN'(INSTR_BYTES);
            if (resp_take) resp_pc_next  = resp_pc_reg + XLEN'(INSTR_BYTES);
            outstanding_next = outstanding_reg
                             + (gnt_fire  ? CW'(1) : CW'(0))
                             - (resp_take ? CW'(1) : CW'(0));
            if (resp_drop) drop_next = drop_reg - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fetch_pc_reg    <= RESET_PC;
            resp_pc_reg     <= RESET_PC;
            outstanding_reg <= '0;
            drop_reg        <= '0;
        end else begin
            fetch_pc_reg    <= fetch_pc_next;
            resp_pc_reg     <= resp_pc_next;
            outstanding_reg <= outstanding_next;
            drop_reg        <= drop_next;
        end
    end

    assert property (@(posedge clk) disable iff (!reset)
        !(imem_rvalid && outstanding_reg == '0 && drop_reg == '0));

endmodule
